ddr2_port_arbiter: RTL

- Round-robin arbiter sharing the single native command port of the DDR2 memory controller between NREQ on-chip requesters (e.g. CPU bus bridge, debug/loader, DMA).
- Registers one command at a time toward the controller.
- Tracks outstanding reads in an in-order tag FIFO and routes read data back to the requester that issued each read.
- Sits between the system interconnect and the controller's native command port in the nexys4ddr board top.

---
 rtl/ddr2_arb_pkg.sv | 37 +++
 rtl/ddr2_arb_tagfifo.sv | 51 +++++
 rtl/ddr2_port_arbiter.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/ddr2_arb_pkg.sv
// Shared types and helpers for the DDR2 native-port arbiter.
package ddr2_arb_pkg;

  localparam int NREQ       = 2;
  localparam int MAX_REQ    = 8;
  localparam int PERF_CNT_W = 32;

  typedef logic [$clog2(NREQ)-1:0] tag_t;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } cmd_state_e;

  typedef struct packed {
    logic       found;
    logic [2:0] idx;
  } pick_t;

  // First set bit of valid[0..n-1], searching from ptr+1 and wrapping modulo n.
  function automatic pick_t rr_pick(input logic [MAX_REQ-1:0] valid,
                                    input logic [2:0]         ptr,
                                    input int unsigned        n);
    pick_t       r;
    int unsigned j;
    r = {1'b0, 3'd0};
    for (int unsigned k = 1; k <= MAX_REQ; k++) begin
      j = (32'(ptr) + k) % n;
      if (k <= n && !r.found && valid[j[2:0]]) begin
        r.found = 1'b1;
        r.idx   = j[2:0];
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/ddr2_arb_tagfifo.sv
// In-order FIFO of requester tags for reads still waiting on controller data.
module ddr2_arb_tagfifo #(
  parameter int DEPTH = 8,
  parameter int W     = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push_i,
  input  logic [W-1:0]           push_tag_i,
  input  logic                   pop_i,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [$clog2(DEPTH):0] count_o,
  output logic [W-1:0]           head_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [W-1:0]  mem_q [DEPTH];
  logic [PW-1:0] wr_q;
  logic [PW-1:0] rd_q;
  logic [CW-1:0] cnt_q;
  logic          do_push_s;
  logic          do_pop_s;

  assign full_o    = (cnt_q == CW'(DEPTH));
  assign empty_o   = (cnt_q == {CW{1'b0}});
  assign count_o   = cnt_q;
  assign head_o    = mem_q[rd_q];
  assign do_push_s = push_i && !full_o;
  assign do_pop_s  = pop_i && !empty_o;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q  <= {PW{1'b0}};
      rd_q  <= {PW{1'b0}};
      cnt_q <= {CW{1'b0}};
    end else begin
      if (do_push_s) begin
        mem_q[wr_q] <= push_tag_i;
        wr_q        <= wr_q + 1'b1;
      end
      if (do_pop_s) begin
        rd_q <= rd_q + 1'b1;
      end
      cnt_q <= cnt_q + CW'(do_push_s) - CW'(do_pop_s);
    end
  end

endmodule

// File: rtl/ddr2_port_arbiter.sv
// Round-robin sharing of the DDR2 controller native command port with in-order read return.
// Optional DDR2_ARB_PERF_EN adds per-requester grant counters and a command stall counter.
module ddr2_port_arbiter #(
  parameter int NREQ      = 2,
  parameter int AW        = 27,
  parameter int DW        = 128,
  parameter int MW        = DW / 8,
  parameter int RDQ_DEPTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [NREQ-1:0]      req_we,
  input  logic [NREQ*AW-1:0]   req_addr,
  input  logic [NREQ*DW-1:0]   req_wdata,
  input  logic [NREQ*MW-1:0]   req_wmask,
  output logic [NREQ-1:0]      rsp_valid,
  output logic [DW-1:0]        rsp_rdata,
  output logic                 mem_cmd_valid,
  input  logic                 mem_cmd_ready,
  output logic                 mem_cmd_we,
  output logic [AW-1:0]        mem_cmd_addr,
  output logic [DW-1:0]        mem_cmd_wdata,
  output logic [MW-1:0]        mem_cmd_wmask,
  input  logic                 mem_rsp_valid,
  input  logic [DW-1:0]        mem_rsp_rdata,
  output logic                 err_orphan
`ifdef DDR2_ARB_PERF_EN
  ,
  output logic [NREQ*32-1:0]   perf_grants,
  output logic [31:0]          perf_stall
`endif
);

  import ddr2_arb_pkg::*;

  localparam int TW = $clog2(NREQ);
  localparam int CW = $clog2(RDQ_DEPTH) + 1;

  cmd_state_e     state_q;
  logic [TW-1:0]  ptr_q;
  logic           cmd_we_q;
  logic [AW-1:0]  cmd_addr_q;
  logic [DW-1:0]  cmd_wdata_q;
  logic [MW-1:0]  cmd_wmask_q;
  logic [NREQ-1:0] rsp_valid_q;
  logic [DW-1:0]  rsp_rdata_q;
  logic           err_q;

  pick_t          pick_s;
  logic [NREQ-1:0] elig_s;
  logic           accept_s;
  logic           grant_s;
  logic           push_s;
  logic           pop_s;
  logic           fifo_full_s;
  logic           fifo_empty_s;
  logic [CW-1:0]  fifo_count_s;
  logic [TW-1:0]  fifo_head_s;
  logic           sel_we_s;
  logic [AW-1:0]  sel_addr_s;
  logic [DW-1:0]  sel_wdata_s;
  logic [MW-1:0]  sel_wmask_s;

  assign accept_s = (state_q == ST_EMPTY) || mem_cmd_ready;
  assign pop_s    = mem_rsp_valid && (fifo_count_s != {CW{1'b0}});

  // A full tag FIFO blocks reads even when a pop lands in the same cycle.
  always_comb begin
    elig_s      = req_valid & (req_we | {NREQ{!fifo_full_s}});
    pick_s      = rr_pick(8'(elig_s), 3'(ptr_q), NREQ);
    grant_s     = accept_s && pick_s.found && !rst;
    sel_we_s    = 1'b0;
    sel_addr_s  = {AW{1'b0}};
    sel_wdata_s = {DW{1'b0}};
    sel_wmask_s = {MW{1'b0}};
    req_ready   = {NREQ{1'b0}};
    for (int i = 0; i < NREQ; i++) begin
      sel_we_s     = (pick_s.idx == 3'(i)) ? req_we[i]              : sel_we_s;
      sel_addr_s   = (pick_s.idx == 3'(i)) ? req_addr[i*AW +: AW]   : sel_addr_s;
      sel_wdata_s  = (pick_s.idx == 3'(i)) ? req_wdata[i*DW +: DW]  : sel_wdata_s;
      sel_wmask_s  = (pick_s.idx == 3'(i)) ? req_wmask[i*MW +: MW]  : sel_wmask_s;
      req_ready[i] = grant_s && (pick_s.idx == 3'(i));
    end
    push_s = grant_s && !sel_we_s;
  end

  ddr2_arb_tagfifo #(
    .DEPTH (RDQ_DEPTH),
    .W     (TW)
  ) u_tagfifo (
    .clk        (clk),
    .rst        (rst),
    .push_i     (push_s),
    .push_tag_i (TW'(pick_s.idx)),
    .pop_i      (pop_s),
    .full_o     (fifo_full_s),
    .empty_o    (fifo_empty_s),
    .count_o    (fifo_count_s),
    .head_o     (fifo_head_s)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_EMPTY;
      ptr_q       <= TW'(NREQ - 1);
      cmd_we_q    <= 1'b0;
      cmd_addr_q  <= {AW{1'b0}};
      cmd_wdata_q <= {DW{1'b0}};
      cmd_wmask_q <= {MW{1'b0}};
      rsp_valid_q <= {NREQ{1'b0}};
      rsp_rdata_q <= {DW{1'b0}};
      err_q       <= 1'b0;
    end else begin
      if (grant_s) begin
        state_q     <= ST_FULL;
        ptr_q       <= TW'(pick_s.idx);
        cmd_we_q    <= sel_we_s;
        cmd_addr_q  <= sel_addr_s;
        cmd_wdata_q <= sel_wdata_s;
        cmd_wmask_q <= sel_wmask_s;
      end else if (accept_s) begin
        state_q <= ST_EMPTY;
      end
      rsp_valid_q <= {NREQ{1'b0}};
      if (pop_s) begin
        rsp_valid_q[fifo_head_s] <= 1'b1;
        rsp_rdata_q              <= mem_rsp_rdata;
      end
      if (mem_rsp_valid && fifo_empty_s) begin
        err_q <= 1'b1;
      end
    end
  end

  assign mem_cmd_valid = (state_q == ST_FULL);
  assign mem_cmd_we    = cmd_we_q;
  assign mem_cmd_addr  = cmd_addr_q;
  assign mem_cmd_wdata = cmd_wdata_q;
  assign mem_cmd_wmask = cmd_wmask_q;
  assign rsp_valid     = rsp_valid_q;
  assign rsp_rdata     = rsp_rdata_q;
  assign err_orphan    = err_q;

`ifdef DDR2_ARB_PERF_EN
  logic [PERF_CNT_W-1:0] grant_cnt_q [NREQ];
  logic [PERF_CNT_W-1:0] stall_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREQ; i++) begin
        grant_cnt_q[i] <= {PERF_CNT_W{1'b0}};
      end
      stall_cnt_q <= {PERF_CNT_W{1'b0}};
    end else begin
      for (int i = 0; i < NREQ; i++) begin
        if (req_ready[i]) begin
          grant_cnt_q[i] <= grant_cnt_q[i] + 1'b1;
        end
      end
      if (mem_cmd_valid && !mem_cmd_ready) begin
        stall_cnt_q <= stall_cnt_q + 1'b1;
      end
    end
  end

  always_comb begin
    for (int i = 0; i < NREQ; i++) begin
      perf_grants[i*32 +: 32] = grant_cnt_q[i];
    end
  end

  assign perf_stall = stall_cnt_q;
`endif

endmodule
